// File: rtl/acc_write_sequencer_if.sv
// rtl/acc_write_sequencer_if.sv - instruction handshake and accumulator write bundle
//
// Purpose: groups the instruction handshake from the decoder and the
//          accumulator write port of the write sequencer.
// Ports (signals):
//   instr_valid/instr_ready         instruction handshake
//   instr_acc_addr/length/accumulate instruction payload
//   acc_wr_en/acc_wr_addr/acc_accumulate accumulator write port
//   busy/done                       instruction status
// Modports: master = decoder/accumulator side, slave = sequencer.
interface acc_write_sequencer_if #(
  parameter int ACC_ADDR_WIDTH = 16,
  parameter int LENGTH_WIDTH   = 32
);
  logic                      instr_valid;
  logic                      instr_ready;
  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr;
  logic [LENGTH_WIDTH-1:0]   instr_length;
  logic                      instr_accumulate;
  logic                      acc_wr_en;
  logic [ACC_ADDR_WIDTH-1:0] acc_wr_addr;
  logic                      acc_accumulate;
  logic                      busy;
  logic                      done;

  modport master (
    output instr_valid, instr_acc_addr, instr_length, instr_accumulate,
    input  instr_ready, acc_wr_en, acc_wr_addr, acc_accumulate, busy, done
  );

  modport slave (
    input  instr_valid, instr_acc_addr, instr_length, instr_accumulate,
    output instr_ready, acc_wr_en, acc_wr_addr, acc_accumulate, busy, done
  );
endinterface

// File: rtl/acc_write_sequencer.sv
// rtl/acc_write_sequencer.sv - accumulator write address sequencer with latency-matched delay line
//
// Purpose: accepts one matrix-multiply instruction at a time, generates one
//          accumulator write address per row and delays address/flag through
//          an enable-gated pipeline so they meet the systolic result data.
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   enable global pipeline advance shared with the systolic datapath
//   bus    slave side of acc_write_sequencer_if (instruction in, writes out)
module acc_write_sequencer #(
  parameter int MATRIX_WIDTH   = 14,
  parameter int ACC_ADDR_WIDTH = 16,
  parameter int LENGTH_WIDTH   = 32,
  parameter int PIPE_DELAY     = 2*MATRIX_WIDTH+2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  acc_write_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ACC_ADDR_WIDTH-1:0] base_q;
  logic [LENGTH_WIDTH-1:0]   len_q;
  logic [LENGTH_WIDTH-1:0]   row_idx_q;
  logic                      acc_q;
  logic                      zero_done_q;

  // Delay line; pipe_last tags the final row so DRAIN knows when to finish.
  logic [PIPE_DELAY-1:0]     pipe_valid;
  logic [PIPE_DELAY-1:0]     pipe_last;
  logic [PIPE_DELAY-1:0]     pipe_acc;
  logic [ACC_ADDR_WIDTH-1:0] pipe_addr [PIPE_DELAY];

  logic accept;
  logic push;
  logic push_last;
  logic last_valid;
  logic final_emit;

  assign accept     = bus.instr_valid & bus.instr_ready;
  assign push       = (state_q == ISSUE) & enable;
  assign push_last  = (row_idx_q == len_q - LENGTH_WIDTH'(1));
  assign last_valid = pipe_valid[PIPE_DELAY-1];
  assign final_emit = (state_q == DRAIN) & last_valid & pipe_last[PIPE_DELAY-1] & enable;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (bus.instr_length != '0)) state_d = ISSUE;
      ISSUE:   if (push && push_last)                  state_d = DRAIN;
      DRAIN:   if (final_emit)                         state_d = IDLE;
      default:                                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      row_idx_q   <= '0;
      acc_q       <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // A zero-length instruction completes in the following cycle with no writes.
      zero_done_q <= accept && (bus.instr_length == '0);
      if (accept) begin
        base_q    <= bus.instr_acc_addr;
        len_q     <= bus.instr_length;
        acc_q     <= bus.instr_accumulate;
        row_idx_q <= '0;
      end else if (push) begin
        row_idx_q <= row_idx_q + LENGTH_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      pipe_acc   <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_addr[i] <= '0;
    end else if (enable) begin
      // Outside ISSUE the push is a bubble: valid=0 and zero payload.
      pipe_valid[0] <= push;
      pipe_last[0]  <= push & push_last;
      pipe_acc[0]   <= push & acc_q;
      pipe_addr[0]  <= push ? (base_q + ACC_ADDR_WIDTH'(row_idx_q)) : '0;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_acc[i]   <= pipe_acc[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
      end
    end
  end

  // Write strobe is gated by enable so a stalled final stage is not written twice.
  assign bus.instr_ready    = ~rst & (state_q == IDLE) & ~zero_done_q;
  assign bus.acc_wr_en      = last_valid & enable;
  assign bus.acc_wr_addr    = last_valid ? pipe_addr[PIPE_DELAY-1] : '0;
  assign bus.acc_accumulate = last_valid & pipe_acc[PIPE_DELAY-1];
  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = zero_done_q | final_emit;

endmodule
